// File: rtl/div_share_pkg.sv
// Shared types and constants for the shared-divider controller.
// Holds the FSM encoding, fixed result codes and a width helper.
package div_share_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_e;

    // Sliced down to W bits at the point of use.
    localparam logic [63:0] DIV0_QUOT    = '1;
    localparam logic [63:0] TIMEOUT_QUOT = '0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above
// the pointer, wrapping around to bit 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one restoring divider among NREQ requesters, round-robin,
// with divide-by-zero and hung-divider guards. All outputs registered.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_quotient,
    output logic              resp_err,
    output logic              busy,
    output logic              div_start,
    output logic [W-1:0]      div_data_in,
    input  logic              div_done,
    input  logic [W-1:0]      div_q
);

    localparam int PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
    localparam int CW = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [W-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] rv_q, rv_d;
    logic [W-1:0]    quot_q, quot_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic [W-1:0]    data_q, data_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gidx;
    logic            any_req;
    logic [W-1:0]    op_a, op_b;
    logic [NREQ-1:0] own_oh;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (any_req)
    );

    assign op_a   = req_dividend[int'(gidx)*W +: W];
    assign op_b   = req_divisor[int'(gidx)*W +: W];
    assign own_oh = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rv_d    = '0;
        quot_d  = quot_q;
        err_d   = err_q;
        start_d = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    idx_d = gidx;
                    b_d   = op_b;
                    if (int'(gidx) == NREQ - 1) ptr_d = '0;
                    else                        ptr_d = gidx + PW'(1);
                    if (op_b == '0) begin
                        state_d = S_RESP;
                        rv_d    = gnt;
                        quot_d  = DIV0_QUOT[W-1:0];
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD_A;
                        start_d = 1'b1;
                        data_d  = op_a;
                    end
                end
            end
            S_LOAD_A: begin
                state_d = S_LOAD_B;
                data_d  = b_q;
            end
            S_LOAD_B: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // done has priority over the timeout on the same cycle
                if (div_done) begin
                    state_d = S_RESP;
                    rv_d    = own_oh;
                    quot_d  = div_q;
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    rv_d    = own_oh;
                    quot_d  = TIMEOUT_QUOT[W-1:0];
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rv_q    <= '0;
            quot_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            quot_q  <= quot_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            data_q  <= data_d;
        end
    end

    assign resp_valid    = rv_q;
    assign resp_quotient = quot_q;
    assign resp_err      = err_q;
    assign busy          = busy_q;
    assign div_start     = start_q;
    assign div_data_in   = data_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: directed scenarios plus random traffic
// against a round-robin / arithmetic reference and a divider model.
module tb_div_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_quotient;
    logic              resp_err;
    logic              busy;
    logic              div_start;
    logic [W-1:0]      div_data_in;
    logic              div_done = 1'b0;
    logic [W-1:0]      div_q = '0;

    always #5 clk = ~clk;

    div_share_ctrl #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .resp_valid    (resp_valid),
        .resp_quotient (resp_quotient),
        .resp_err      (resp_err),
        .busy          (busy),
        .div_start     (div_start),
        .div_data_in   (div_data_in),
        .div_done      (div_done),
        .div_q         (div_q)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: start beat carries dividend, next beat divisor,
    // done pulses in WAIT cycle number dly (1-based) unless never.
    int          dly = 5;
    bit          never = 1'b0;
    int          ph = 0;
    int          k = 0;
    int          starts = 0;
    int          ndone = 0;
    int          wait_cyc = 0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;

    always @(negedge clk) begin
        div_done = 1'b0;
        if (div_start) begin
            starts = starts + 1;
            ma = div_data_in;
            ph = 1;
        end else if (ph == 1) begin
            mb = div_data_in;
            ph = 2;
            k = 0;
        end else if (ph == 2) begin
            k = k + 1;
            if (k == 1) wait_cyc = cyc;
            if (!never && k == dly) begin
                div_done = 1'b1;
                div_q = (mb == 0) ? '1 : ma / mb;
                ndone = ndone + 1;
                ph = 0;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    bit [NREQ-1:0] pend = '0;
    logic [W-1:0]  oa [NREQ];
    logic [W-1:0]  ob [NREQ];
    int            mptr = 0;
    bit            exp_to = 1'b0;
    int            lastn = 0;
    int            lastg = 0;
    int            resp_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply();
        req = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*W +: W] = oa[i];
            req_divisor[i*W +: W]  = ob[i];
        end
    endtask

    task automatic post(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        oa[i] = a;
        ob[i] = b;
        pend[i] = 1'b1;
        apply();
    endtask

    task automatic wait_resp(input string tag, input int budget);
        int n;
        int e;
        int j;
        logic [W-1:0] eq;
        logic ee;
        logic [NREQ-1:0] eoh;
        n = 0;
        e = 0;
        for (int s = NREQ - 1; s >= 0; s--) begin
            j = (mptr + s) % NREQ;
            if (pend[j]) e = j;
        end
        if (ob[e] == 0) begin
            eq = '1;
            ee = 1'b1;
        end else if (exp_to) begin
            eq = '0;
            ee = 1'b1;
        end else begin
            eq = oa[e] / ob[e];
            ee = 1'b0;
        end
        eoh = '0;
        eoh[e] = 1'b1;
        while (resp_valid == '0 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        assert (n < budget) else begin
            fails++;
            $error("FAIL %s_wait observed=%0d expected<%0d", tag, n, budget);
        end
        chk({tag, "_valid"}, 32'(resp_valid), 32'(eoh));
        chk({tag, "_quot"}, 32'(resp_quotient), 32'(eq));
        chk({tag, "_err"}, 32'(resp_err), 32'(ee));
        lastn = n;
        resp_cyc = cyc;
        lastg = 0;
        for (int i = 0; i < NREQ; i++) if (resp_valid[i]) lastg = i;
        pend[e] = 1'b0;
        req = pend;
        mptr = (e + 1) % NREQ;
        tick();
        chk({tag, "_strobe1"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int s0;
        int nd0;
        int seen;
        bit [NREQ-1:0] nw;
        rst = 1'b1;
        req = '0;
        req_dividend = '0;
        req_divisor = '0;
        for (int i = 0; i < NREQ; i++) begin
            oa[i] = '0;
            ob[i] = 8'd1;
        end
        #12;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_data", 32'(div_data_in), 32'd0);
        chk("rst_quot", 32'(resp_quotient), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // single request
        s0 = starts;
        dly = 7;
        post(0, 8'd50, 8'd2);
        tick();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_resp("t1", 40);
        chk("t1_q25", 32'(resp_quotient), 32'd25);
        chk("t1_beatA", 32'(ma), 32'd50);
        chk("t1_beatB", 32'(mb), 32'd2);
        chk("t1_starts", 32'(starts - s0), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // contention and rotation
        dly = 3;
        post(1, 8'd100, 8'd10);
        post(3, 8'd81, 8'd9);
        wait_resp("t2a", 40);
        chk("t2a_grant", 32'(lastg), 32'd1);
        post(0, 8'd77, 8'd7);
        wait_resp("t2b", 40);
        chk("t2b_grant", 32'(lastg), 32'd3);
        wait_resp("t2c", 40);
        chk("t2c_grant", 32'(lastg), 32'd0);

        // divide by zero
        s0 = starts;
        post(2, 8'd7, 8'd0);
        wait_resp("t3", 10);
        chk("t3_lat", 32'(lastn), 32'd1);
        chk("t3_nostart", 32'(starts - s0), 32'd0);

        // timeout, then a normal request
        never = 1'b1;
        exp_to = 1'b1;
        post(1, 8'd9, 8'd3);
        wait_resp("t4", 100);
        chk("t4_lat", 32'(resp_cyc - wait_cyc), 32'(TO));
        never = 1'b0;
        exp_to = 1'b0;
        dly = 3;
        post(3, 8'd200, 8'd7);
        wait_resp("t4b", 40);

        // reset during WAIT with a late done
        dly = 12;
        nd0 = ndone;
        post(2, 8'd60, 8'd4);
        seen = 0;
        while (!(ph == 2 && k >= 3) && seen < 30) begin
            tick();
            seen++;
        end
        chk("t5_inwait", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_start", 32'(div_start), 32'd0);
        tick();
        rst = 1'b0;
        pend = '0;
        req = '0;
        mptr = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (resp_valid != '0 || busy) seen++;
        end
        chk("t5_late_done", 32'(ndone - nd0), 32'd1);
        chk("t5_quiet", 32'(seen), 32'd0);
        dly = 5;
        post(0, 8'd90, 8'd3);
        wait_resp("t5b", 40);
        chk("t5_q30", 32'(resp_quotient), 32'd30);

        // done on the last WAIT cycle
        dly = TO;
        post(1, 8'd120, 8'd5);
        wait_resp("t6", 60);

        // random traffic
        for (int it = 0; it < 40; it++) begin
            nw = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~pend;
            if ((pend | nw) == '0) nw[$urandom_range(0, NREQ - 1)] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (nw[i]) begin
                    oa[i] = W'($urandom);
                    ob[i] = ($urandom_range(0, 7) == 0) ? '0
                          : W'($urandom_range(1, (1 << W) - 1));
                    pend[i] = 1'b1;
                end
            end
            apply();
            dly = $urandom_range(1, TO);
            wait_resp("rnd", 60);
        end
        while (pend != '0) wait_resp("drain", 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1);
    end

endmodule
